// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the arbiter state encoding, the header tag nibble and a compile-time log2 helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_RELEASE = 3'd4
    } arb_state_t;

    localparam logic [3:0] HDR_TAG = 4'hA;

    // Ceiling log2, used to size counters and indices at elaboration time.
    function automatic int clog2(input int value);
        int res;
        res = 32'sd0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 32'sd1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Channel header byte: tag nibble followed by the requester id.
    function automatic logic [7:0] hdr_byte(input logic [3:0] id);
        return {HDR_TAG, id};
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
// Produces a one-hot pick, an any-request flag and the binary id of the winner.
module rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] pick,
    output logic             any,
    output logic [ID_W-1:0]  id
);

    // Rotating scan from ptr; the first hit blocks every later candidate.
    always_comb begin
        int  k;
        logic hit_s;
        k     = 32'sd0;
        hit_s = 1'b0;
        pick  = '0;
        any   = 1'b0;
        id    = '0;
        for (int j = 0; j < N_REQ; j++) begin
            k       = (int'(ptr) + j) % N_REQ;
            hit_s   = !any && req[k];
            pick[k] = pick[k] | hit_s;
            id      = hit_s ? ID_W'(k) : id;
            any     = any | hit_s;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter feeding one UART TX FIFO from N_REQ byte streams.
// Grants whole packets, optionally prefixes a channel header and truncates overlong packets.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int HDR_EN  = 1,
    parameter int MAX_LEN = 255
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         fifo_din,
    output logic               fifo_wr_en,
    input  logic               fifo_full,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic               trunc_err
);

    localparam int ID_W  = clog2(N_REQ);
    localparam int CNT_W = clog2(MAX_LEN + 1);
    localparam bit HDR_ON = (HDR_EN != 32'sd0);

    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);
    localparam logic [ID_W-1:0]  ID_ONE   = ID_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_LEN - 1);

    arb_state_t         state_r, state_s;
    logic [N_REQ-1:0]   grant_r, grant_s;
    logic [ID_W-1:0]    gid_r, gid_s;
    logic [ID_W-1:0]    rr_ptr_r, rr_ptr_s;
    logic [CNT_W-1:0]   byte_cnt_r, byte_cnt_s;
    logic               trunc_err_r, trunc_s;

    logic [N_REQ-1:0]   pick_s;
    logic               pick_any_s;
    logic [ID_W-1:0]    pick_id_s;

    logic [7:0]         gdata_s;
    logic               gvalid_s;
    logic               glast_s;
    logic               accept_s;

    rr_pick #(
        .N_REQ(N_REQ),
        .ID_W (ID_W)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (rr_ptr_r),
        .pick(pick_s),
        .any (pick_any_s),
        .id  (pick_id_s)
    );

    assign gdata_s  = req_data[{gid_r, 3'b000} +: 8];
    assign gvalid_s = req_valid[gid_r];
    assign glast_s  = req_last[gid_r];
    assign accept_s = gvalid_s && !fifo_full;

    assign grant     = grant_r;
    assign busy      = (state_r != ST_IDLE);
    assign trunc_err = trunc_err_r;

    // Next-state, bookkeeping and FIFO/handshake output decode.
    always_comb begin
        state_s    = state_r;
        grant_s    = grant_r;
        gid_s      = gid_r;
        rr_ptr_s   = rr_ptr_r;
        byte_cnt_s = byte_cnt_r;
        trunc_s    = 1'b0;
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        fifo_din   = 8'h00;

        case (state_r)
            ST_IDLE: begin
                if (pick_any_s) begin
                    grant_s    = pick_s;
                    gid_s      = pick_id_s;
                    byte_cnt_s = '0;
                    state_s    = HDR_ON ? ST_HDR : ST_PAYLOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_HDR: begin
                fifo_din   = hdr_byte(4'(gid_r));
                fifo_wr_en = !fifo_full;
                if (!fifo_full) begin
                    state_s = ST_PAYLOAD;
                end else begin
                    state_s = ST_HDR;
                end
            end

            ST_PAYLOAD: begin
                // Ready depends only on the grant and fifo_full, never on req_valid.
                req_ready  = fifo_full ? '0 : grant_r;
                fifo_din   = gdata_s;
                fifo_wr_en = accept_s;
                if (accept_s) begin
                    byte_cnt_s = (byte_cnt_r == CNT_MAX) ? byte_cnt_r : byte_cnt_r + CNT_ONE;
                    if (glast_s) begin
                        state_s = ST_RELEASE;
                    end else if (byte_cnt_r == LAST_IDX) begin
                        trunc_s = 1'b1;
                        state_s = ST_DRAIN;
                    end else begin
                        state_s = ST_PAYLOAD;
                    end
                end else begin
                    state_s = ST_PAYLOAD;
                end
            end

            ST_DRAIN: begin
                req_ready = grant_r;
                if (gvalid_s && glast_s) begin
                    state_s = ST_RELEASE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end

            ST_RELEASE: begin
                rr_ptr_s = (gid_r == LAST_ID) ? '0 : gid_r + ID_ONE;
                grant_s  = '0;
                state_s  = ST_IDLE;
            end

            default: begin
                grant_s = '0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, grant, pointer, byte counter and truncation pulse registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            grant_r     <= '0;
            gid_r       <= '0;
            rr_ptr_r    <= '0;
            byte_cnt_r  <= '0;
            trunc_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            grant_r     <= grant_s;
            gid_r       <= gid_s;
            rr_ptr_r    <= rr_ptr_s;
            byte_cnt_r  <= byte_cnt_s;
            trunc_err_r <= trunc_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: packet queues per requester drive two DUT
// configurations; a packet-level round-robin model predicts the FIFO byte stream.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [3:0]  a_valid, a_last, a_ready, a_grant;
    logic [31:0] a_data;
    logic [7:0]  a_din;
    logic        a_wr, a_full, a_busy, a_trunc;

    logic [3:0]  b_valid, b_last, b_ready, b_grant;
    logic [31:0] b_data;
    logic [7:0]  b_din;
    logic        b_wr, b_full, b_busy, b_trunc;

    uart_tx_arbiter #(.N_REQ(4), .HDR_EN(1), .MAX_LEN(4)) dut_a (
        .clk_in(clk), .rst_n(rst_n), .req_valid(a_valid), .req_data(a_data),
        .req_last(a_last), .req_ready(a_ready), .fifo_din(a_din), .fifo_wr_en(a_wr),
        .fifo_full(a_full), .grant(a_grant), .busy(a_busy), .trunc_err(a_trunc)
    );

    uart_tx_arbiter #(.N_REQ(4), .HDR_EN(0), .MAX_LEN(255)) dut_b (
        .clk_in(clk), .rst_n(rst_n), .req_valid(b_valid), .req_data(b_data),
        .req_last(b_last), .req_ready(b_ready), .fifo_din(b_din), .fifo_wr_en(b_wr),
        .fifo_full(b_full), .grant(b_grant), .busy(b_busy), .trunc_err(b_trunc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] pq [4][$];
    bit         first_b [4];
    logic [7:0] obs_b[$], exp_b[$];
    logic [3:0] obs_g[$], exp_g[$];
    int         obs_c[$];
    int         exp_trunc, trunc_n, trunc_c, busy_cnt, bad_full, full_rdy, cyc;
    int         grant_cnt [4];

    task automatic do_reset();
        rst_n = 1'b0;
        a_valid = '0; a_last = '0; a_data = '0; a_full = 1'b0;
        b_valid = '0; b_last = '0; b_data = '0; b_full = 1'b0;
        for (int r = 0; r < 4; r++) pq[r].delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic add_pkt(input int r, input int len, input logic [7:0] base, input logic [7:0] step);
        logic [7:0] b;
        b = base;
        for (int i = 0; i < len; i++) begin
            pq[r].push_back({(i == len - 1), b});
            b = b + step;
        end
    endtask

    // Packet-level prediction: round robin over requesters holding packets, header, truncation.
    task automatic build_exp(input bit hdr, input int maxlen);
        logic [8:0] mq [4][$];
        logic [8:0] e;
        int ptr, w, cnt;
        for (int r = 0; r < 4; r++) mq[r] = pq[r];
        exp_b.delete(); exp_g.delete();
        exp_trunc = 0;
        ptr = 0;
        while (1) begin
            w = -1;
            for (int j = 0; j < 4; j++)
                if (w < 0 && mq[(ptr + j) % 4].size() > 0) w = (ptr + j) % 4;
            if (w < 0) break;
            if (hdr) begin exp_b.push_back(8'hA0 | 8'(w)); exp_g.push_back(4'(1 << w)); end
            cnt = 0;
            do begin
                e = mq[w].pop_front();
                if (cnt < maxlen) begin exp_b.push_back(e[7:0]); exp_g.push_back(4'(1 << w)); end
                cnt++;
            end while (!e[8] && mq[w].size() > 0);
            if (cnt > maxlen) exp_trunc++;
            ptr = (w + 1) % 4;
        end
    endtask

    // Cycle driver/monitor: full_at 0 = never full, 1 = random, >1 = 4-cycle window from that cycle.
    task automatic run_pkts(input int inst, input bit gaps, input int full_at, input int abort_at);
        logic [3:0]  v, l, rdy, g;
        logic [31:0] d;
        logic [7:0]  din;
        logic        f, wr, bz, tr;
        int          idle_n;
        bit          done, empty;
        obs_b.delete(); obs_g.delete(); obs_c.delete();
        trunc_n = 0; trunc_c = -1; busy_cnt = 0; bad_full = 0; full_rdy = 0; cyc = 0;
        idle_n = 0; done = 1'b0;
        for (int r = 0; r < 4; r++) begin first_b[r] = 1'b1; grant_cnt[r] = 0; end
        while (!done) begin
            @(negedge clk);
            v = '0; l = '0; d = '0;
            for (int r = 0; r < 4; r++) begin
                if (pq[r].size() > 0) begin
                    v[r] = first_b[r] || !gaps || ($urandom_range(3, 0) != 0);
                    d[r*8 +: 8] = pq[r][0][7:0];
                    l[r] = pq[r][0][8];
                end
            end
            if (full_at == 1) f = ($urandom_range(3, 0) == 0);
            else f = (full_at > 1) && (cyc >= full_at) && (cyc < full_at + 4);
            if (inst == 0) begin a_valid = v; a_data = d; a_last = l; a_full = f; end
            else begin b_valid = v; b_data = d; b_last = l; b_full = f; end
            #1;
            if (inst == 0) begin rdy = a_ready; wr = a_wr; din = a_din; g = a_grant; bz = a_busy; tr = a_trunc; end
            else begin rdy = b_ready; wr = b_wr; din = b_din; g = b_grant; bz = b_busy; tr = b_trunc; end
            if (f && wr) bad_full++;
            if (f && rdy != 4'b0) full_rdy++;
            for (int r = 0; r < 4; r++) begin
                if (v[r] && rdy[r]) begin void'(pq[r].pop_front()); first_b[r] = l[r]; end
                if (g == 4'(1 << r)) grant_cnt[r]++;
            end
            if (wr) begin obs_b.push_back(din); obs_g.push_back(g); obs_c.push_back(cyc); end
            if (tr) begin trunc_n++; trunc_c = cyc; end
            if (bz) busy_cnt++;
            empty = 1'b1;
            for (int r = 0; r < 4; r++) if (pq[r].size() > 0) empty = 1'b0;
            idle_n = (empty && !bz) ? idle_n + 1 : 0;
            cyc++;
            if (idle_n >= 2 || (abort_at >= 0 && cyc >= abort_at)) done = 1'b1;
            else if (cyc >= 3000) begin
                n_checks++; n_errors++;
                $display("FAIL run_timeout inst=%0d got cycles=%0d want completion", inst, cyc);
                done = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a_grant, a_busy, a_wr, a_din, a_ready, a_trunc} !== 19'd0) begin
            n_errors++; $display("FAIL reset_a got %h want 0", {a_grant, a_busy, a_wr, a_din, a_ready, a_trunc});
        end
        n_checks++;
        if ({b_grant, b_busy, b_wr, b_din, b_ready, b_trunc} !== 19'd0) begin
            n_errors++; $display("FAIL reset_b got %h want 0", {b_grant, b_busy, b_wr, b_din, b_ready, b_trunc});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({a_grant, a_busy, a_wr, a_ready, b_grant, b_busy, b_wr, b_ready} !== 20'd0) begin
            n_errors++; $display("FAIL idle_after_reset got %h want 0", {a_grant, a_busy, a_wr, a_ready, b_grant, b_busy, b_wr, b_ready});
        end
    endtask

    task automatic test_single();
        logic [7:0] want [4];
        want = '{8'hA0, 8'h11, 8'h22, 8'h33};
        do_reset();
        add_pkt(0, 3, 8'h11, 8'h11);
        run_pkts(0, 1'b0, 0, -1);
        n_checks++;
        if (obs_b.size() !== 4) begin n_errors++; $display("FAIL single_len got %0d want 4", obs_b.size()); end
        for (int i = 0; i < 4 && i < obs_b.size(); i++) begin
            n_checks++;
            if (obs_b[i] !== want[i] || obs_c[i] !== i + 1) begin
                n_errors++; $display("FAIL single_byte[%0d] got %h@%0d want %h@%0d", i, obs_b[i], obs_c[i], want[i], i + 1);
            end
        end
        n_checks++;
        if (grant_cnt[0] !== 5 || busy_cnt !== 5) begin
            n_errors++; $display("FAIL single_grant_cycles got %0d/%0d want 5/5", grant_cnt[0], busy_cnt);
        end
        n_checks++;
        if (a_busy !== 1'b0) begin n_errors++; $display("FAIL single_busy_end got %b want 0", a_busy); end
    endtask

    task automatic test_round_robin();
        logic [7:0] hdrs [4];
        hdrs = '{8'hA1, 8'hA3, 8'hA1, 8'hA3};
        do_reset();
        add_pkt(1, 2, 8'h10, 8'h01); add_pkt(3, 2, 8'h30, 8'h01);
        add_pkt(1, 2, 8'h50, 8'h01); add_pkt(3, 2, 8'h70, 8'h01);
        build_exp(1'b1, 4);
        run_pkts(0, 1'b0, 0, -1);
        n_checks++;
        if (obs_b.size() !== exp_b.size()) begin n_errors++; $display("FAIL rr_len got %0d want %0d", obs_b.size(), exp_b.size()); end
        for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
            n_checks++;
            if ({obs_g[i], obs_b[i]} !== {exp_g[i], exp_b[i]}) begin
                n_errors++; $display("FAIL rr_byte[%0d] got %h/%h want %h/%h", i, obs_g[i], obs_b[i], exp_g[i], exp_b[i]);
            end
        end
        for (int p = 0; p < 4; p++) begin
            n_checks++;
            if (obs_b.size() <= 3 * p || obs_b[3 * p] !== hdrs[p]) begin
                n_errors++; $display("FAIL rr_order[%0d] got %h want %h", p, (obs_b.size() > 3 * p) ? obs_b[3 * p] : 8'h00, hdrs[p]);
            end
        end
    endtask

    task automatic test_fifo_stall();
        int want_c [5];
        want_c = '{1, 2, 7, 8, 9};
        do_reset();
        add_pkt(2, 4, 8'($urandom), 8'h07);
        build_exp(1'b1, 4);
        run_pkts(0, 1'b0, 3, -1);
        n_checks++;
        if (obs_b.size() !== exp_b.size()) begin n_errors++; $display("FAIL stall_len got %0d want %0d", obs_b.size(), exp_b.size()); end
        for (int i = 0; i < exp_b.size() && i < obs_b.size() && i < 5; i++) begin
            n_checks++;
            if (obs_b[i] !== exp_b[i] || obs_c[i] !== want_c[i]) begin
                n_errors++; $display("FAIL stall_byte[%0d] got %h@%0d want %h@%0d", i, obs_b[i], obs_c[i], exp_b[i], want_c[i]);
            end
        end
        n_checks++;
        if (bad_full !== 0 || full_rdy !== 0) begin
            n_errors++; $display("FAIL stall_activity got wr=%0d rdy=%0d want 0/0", bad_full, full_rdy);
        end
    endtask

    task automatic test_truncation();
        do_reset();
        add_pkt(2, 6, 8'h21, 8'h01);
        add_pkt(3, 2, 8'h31, 8'h01);
        build_exp(1'b1, 4);
        run_pkts(0, 1'b0, 0, -1);
        n_checks++;
        if (obs_b.size() !== exp_b.size()) begin n_errors++; $display("FAIL trunc_len got %0d want %0d", obs_b.size(), exp_b.size()); end
        for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
            n_checks++;
            if ({obs_g[i], obs_b[i]} !== {exp_g[i], exp_b[i]}) begin
                n_errors++; $display("FAIL trunc_byte[%0d] got %h/%h want %h/%h", i, obs_g[i], obs_b[i], exp_g[i], exp_b[i]);
            end
        end
        n_checks++;
        if (trunc_n !== exp_trunc || trunc_c !== 6) begin
            n_errors++; $display("FAIL trunc_pulse got %0d@%0d want %0d@6", trunc_n, trunc_c, exp_trunc);
        end
        n_checks++;
        if (obs_c.size() < 6 || obs_c[5] !== 10) begin
            n_errors++; $display("FAIL trunc_next_hdr got %0d want 10", (obs_c.size() > 5) ? obs_c[5] : -1);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        add_pkt(2, 2, 8'h40, 8'h01);
        add_pkt(3, 5, 8'h60, 8'h01);
        run_pkts(0, 1'b0, 0, 9);
        @(negedge clk);
        n_checks++;
        if (a_wr !== 1'b1 || a_grant !== 4'b1000) begin
            n_errors++; $display("FAIL arst_pre got wr=%b grant=%b want 1/1000", a_wr, a_grant);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a_grant, a_wr, a_ready, a_busy} !== 10'd0) begin
            n_errors++; $display("FAIL arst_immediate got %b want 0", {a_grant, a_wr, a_ready, a_busy});
        end
        for (int r = 0; r < 4; r++) pq[r].delete();
        a_valid = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        add_pkt(3, 2, 8'h80, 8'h01);
        add_pkt(1, 2, 8'h90, 8'h01);
        build_exp(1'b1, 4);
        run_pkts(0, 1'b0, 0, -1);
        n_checks++;
        if (obs_b.size() !== exp_b.size() || obs_b.size() == 0 || obs_b[0] !== 8'hA1) begin
            n_errors++; $display("FAIL arst_fresh_hdr got %h (len %0d) want a1", (obs_b.size() > 0) ? obs_b[0] : 8'h00, obs_b.size());
        end
        for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
            n_checks++;
            if ({obs_g[i], obs_b[i]} !== {exp_g[i], exp_b[i]}) begin
                n_errors++; $display("FAIL arst_byte[%0d] got %h/%h want %h/%h", i, obs_g[i], obs_b[i], exp_g[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_no_header();
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 4; r++) add_pkt(r, 1, 8'(r + 16 * k), 8'h00);
        build_exp(1'b0, 255);
        run_pkts(1, 1'b0, 0, -1);
        n_checks++;
        if (obs_b.size() !== 8) begin n_errors++; $display("FAIL nohdr_len got %0d want 8", obs_b.size()); end
        for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
            n_checks++;
            if ({obs_g[i], obs_b[i]} !== {exp_g[i], exp_b[i]} || obs_c[i] !== 1 + 3 * i) begin
                n_errors++; $display("FAIL nohdr_byte[%0d] got %h/%h@%0d want %h/%h@%0d",
                                     i, obs_g[i], obs_b[i], obs_c[i], exp_g[i], exp_b[i], 1 + 3 * i);
            end
        end
    endtask

    task automatic test_random();
        int inst, maxl;
        for (int it = 0; it < 6; it++) begin
            inst = it % 2;
            maxl = (inst == 0) ? 4 : 255;
            do_reset();
            for (int r = 0; r < 4; r++)
                repeat ($urandom_range(3, 0)) add_pkt(r, $urandom_range(7, 1), 8'($urandom), 8'($urandom));
            build_exp(inst == 0, maxl);
            run_pkts(inst, 1'b1, 1, -1);
            n_checks++;
            if (obs_b.size() !== exp_b.size()) begin
                n_errors++; $display("FAIL rand%0d_len got %0d want %0d", it, obs_b.size(), exp_b.size());
            end
            for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
                n_checks++;
                if ({obs_g[i], obs_b[i]} !== {exp_g[i], exp_b[i]}) begin
                    n_errors++; $display("FAIL rand%0d_byte[%0d] got %h/%h want %h/%h", it, i, obs_g[i], obs_b[i], exp_g[i], exp_b[i]);
                end
            end
            n_checks++;
            if (trunc_n !== exp_trunc || bad_full !== 0) begin
                n_errors++; $display("FAIL rand%0d_trunc got %0d wr_on_full=%0d want %0d/0", it, trunc_n, bad_full, exp_trunc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fifo_stall();
        test_truncation();
        test_async_reset();
        test_no_header();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
